// File: rtl/l2_cache.sv
// l2_cache: set-associative L2 between L1 and memory; block reads/writes.
// Optional macro L2_WRITEBACK_EN selects write-back (default: write-through).
module l2_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            l1_addr,
  input  logic                             l1_read,
  input  logic                             l1_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out,
  output logic                             l1_ready,
  output logic                             l1_hit,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic                             mem_ready,
  input  logic [3:0]                       random_num
);

  localparam int OFFW = $clog2(BLOCK_SIZE);
  localparam int SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int IDXW = $clog2(SETS);
  localparam int WAYW = $clog2(NUM_WAYS);
  localparam int TAGW = ADDR_WIDTH - IDXW - OFFW;
  localparam int BLKW = BLOCK_SIZE * DATA_WIDTH;
  localparam int BAW  = ADDR_WIDTH - OFFW;

`ifdef L2_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LOOKUP, EVICT, FILL, WRMEM
  } state_t;

  state_t state, state_d;

  logic [TAGW-1:0] tag_mem  [SETS][NUM_WAYS];
  logic [BLKW-1:0] data_mem [SETS][NUM_WAYS];
  logic [SETS-1:0][NUM_WAYS-1:0] valid;
  logic [SETS-1:0][NUM_WAYS-1:0] dirty;

  logic [BAW-1:0]  req_blk;
  logic [BLKW-1:0] req_data;
  logic            req_wr;
  logic            hit_q;
  logic [WAYW-1:0] vic_q;

  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [ADDR_WIDTH-1:0] blk_addr;

  logic            hit;
  logic [WAYW-1:0] hit_way;
  logic            inv_found;
  logic [WAYW-1:0] inv_way;
  logic [WAYW-1:0] victim;
  logic            vic_dirty;

  logic            wr_en;
  logic [WAYW-1:0] wr_way;
  logic [BLKW-1:0] wr_blk;
  logic            wr_dirty;

  logic unused_bits;

  assign idx      = req_blk[IDXW-1:0];
  assign tag      = req_blk[BAW-1:IDXW];
  assign blk_addr = {req_blk, {OFFW{1'b0}}};
  assign unused_bits = ^{random_num, l1_addr[OFFW-1:0]};

  // Tag compare and lowest-invalid-way search over the addressed set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[idx][w] && tag_mem[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = w[WAYW-1:0];
      end
      if (!valid[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = w[WAYW-1:0];
      end
    end
  end

  // Victim choice: free way first, else the random source
  always_comb begin
    victim    = inv_found ? inv_way : random_num[WAYW-1:0];
    vic_dirty = WB && valid[idx][victim] && dirty[idx][victim];
  end

  // Next state and line-install strobes
  always_comb begin
    state_d  = state;
    wr_en    = 1'b0;
    wr_way   = vic_q;
    wr_blk   = req_data;
    wr_dirty = WB;
    unique case (state)
      IDLE: begin
        if (l1_read || l1_write) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          wr_en   = req_wr;
          wr_way  = hit_way;
          state_d = (req_wr && !WB) ? WRMEM : IDLE;
        end else if (vic_dirty) begin
          state_d = EVICT;
        end else if (!req_wr) begin
          state_d = FILL;
        end else if (WB) begin
          wr_en   = 1'b1;
          wr_way  = victim;
          state_d = IDLE;
        end else begin
          state_d = WRMEM;
        end
      end
      EVICT: begin
        if (mem_ready) begin
          wr_en   = req_wr;
          state_d = req_wr ? IDLE : FILL;
        end
      end
      FILL: begin
        if (mem_ready) begin
          wr_en    = 1'b1;
          wr_blk   = mem_data_in;
          wr_dirty = 1'b0;
          state_d  = IDLE;
        end
      end
      WRMEM: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Line tag/data storage (not reset; guarded by valid)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[idx][wr_way]  <= tag;
      data_mem[idx][wr_way] <= wr_blk;
    end
  end

  // Valid and dirty bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[idx][wr_way] <= 1'b1;
      dirty[idx][wr_way] <= wr_dirty;
    end
  end

  // Request latch and registered L1/memory outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_blk      <= '0;
      req_data     <= '0;
      req_wr       <= 1'b0;
      hit_q        <= 1'b0;
      vic_q        <= '0;
      l1_ready     <= 1'b0;
      l1_hit       <= 1'b0;
      l1_data_out  <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      l1_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (l1_read || l1_write) begin
            req_blk  <= l1_addr[ADDR_WIDTH-1:OFFW];
            req_data <= l1_data_in;
            req_wr   <= ~l1_read;
          end
        end
        LOOKUP: begin
          vic_q <= victim;
          hit_q <= hit;
          unique case (state_d)
            IDLE: begin
              l1_ready <= 1'b1;
              l1_hit   <= hit;
              if (!req_wr) l1_data_out <= data_mem[idx][hit_way];
            end
            EVICT: begin
              mem_write    <= 1'b1;
              mem_addr     <= {tag_mem[idx][victim], idx, {OFFW{1'b0}}};
              mem_data_out <= data_mem[idx][victim];
            end
            FILL: begin
              mem_read <= 1'b1;
              mem_addr <= blk_addr;
            end
            WRMEM: begin
              mem_write    <= 1'b1;
              mem_addr     <= blk_addr;
              mem_data_out <= req_data;
            end
            default: ;
          endcase
        end
        EVICT: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (req_wr) begin
              l1_ready <= 1'b1;
              l1_hit   <= 1'b0;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= blk_addr;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_read    <= 1'b0;
            l1_ready    <= 1'b1;
            l1_hit      <= 1'b0;
            l1_data_out <= mem_data_in;
          end
        end
        WRMEM: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            l1_ready  <= 1'b1;
            l1_hit    <= hit_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
